// File: rtl/send_packet_arbiter.sv
// Two-requester (HC / SOF) arbiter for the shared send-packet port.
// Define SEND_PACKET_ARB_RR_EN for round-robin ties; default is SOF priority.
module send_packet_arbiter #(
    parameter int unsigned INTER_GRANT_GAP = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hcReq,
    input  logic [3:0] hcPID,
    input  logic       hcWEn,
    output logic       hcGnt,
    output logic       hcReady,
    input  logic       sofReq,
    input  logic [3:0] sofPID,
    input  logic       sofWEn,
    output logic       sofGnt,
    output logic       sofReady,
    output logic [3:0] sendPacketCPPID,
    output logic       sendPacketCPWEn,
    input  logic       sendPacketCPReady
);

    typedef enum logic [1:0] {
        IDLE,
        HC_ACT,
        SOF_ACT,
        GAP
    } state_e;

    localparam logic [3:0] GapLd = 4'(INTER_GRANT_GAP);

    state_e     state_q;
    logic       hc_gnt_q;
    logic       sof_gnt_q;
    logic       busy_q;
    logic       last_sof_q;
    logic [3:0] gap_q;
    logic       owner_req;
    logic       release_ok;
    logic       tie_sof;

    always_comb begin
        sendPacketCPPID = 4'h0;
        sendPacketCPWEn = 1'b0;
        if (hc_gnt_q) begin
            sendPacketCPPID = hcPID;
            sendPacketCPWEn = hcWEn;
        end else if (sof_gnt_q) begin
            sendPacketCPPID = sofPID;
            sendPacketCPWEn = sofWEn;
        end
    end

    assign hcGnt    = hc_gnt_q;
    assign sofGnt   = sof_gnt_q;
    assign hcReady  = sendPacketCPReady & hc_gnt_q;
    assign sofReady = sendPacketCPReady & sof_gnt_q;

    assign owner_req  = (hc_gnt_q & hcReq) | (sof_gnt_q & sofReq);
    // A strobe in the release cycle would start a packet we no longer own.
    assign release_ok = ~owner_req & ~busy_q & ~sendPacketCPWEn;

`ifdef SEND_PACKET_ARB_RR_EN
    assign tie_sof = ~last_sof_q;
`else
    // Fixed priority: SOF frame timing wins; last owner is tracked only.
    assign tie_sof = last_sof_q | 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            hc_gnt_q   <= 1'b0;
            sof_gnt_q  <= 1'b0;
            busy_q     <= 1'b0;
            last_sof_q <= 1'b0;
            gap_q      <= 4'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (sofReq && (!hcReq || tie_sof)) begin
                        state_q    <= SOF_ACT;
                        sof_gnt_q  <= 1'b1;
                        last_sof_q <= 1'b1;
                    end else if (hcReq) begin
                        state_q    <= HC_ACT;
                        hc_gnt_q   <= 1'b1;
                        last_sof_q <= 1'b0;
                    end
                end
                HC_ACT, SOF_ACT: begin
                    if (release_ok) begin
                        hc_gnt_q  <= 1'b0;
                        sof_gnt_q <= 1'b0;
                        busy_q    <= 1'b0;
                        if (GapLd != 4'd0) begin
                            state_q <= GAP;
                            gap_q   <= GapLd;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (sendPacketCPWEn) begin
                        busy_q <= 1'b1;
                    end else if (sendPacketCPReady) begin
                        busy_q <= 1'b0;
                    end
                end
                GAP: begin
                    if (gap_q <= 4'd1) begin
                        state_q <= IDLE;
                        gap_q   <= 4'd0;
                    end else begin
                        gap_q <= gap_q - 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_send_packet_arbiter.sv
// Directed plus random stimulus for send_packet_arbiter against an
// ownership/cool-down reference model.
module tb_send_packet_arbiter;

    localparam int GAP_N = 2;
    localparam int NONE = 0;
    localparam int HC = 1;
    localparam int SOF = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       hcReq, hcWEn, hcGnt, hcReady;
    logic [3:0] hcPID;
    logic       sofReq, sofWEn, sofGnt, sofReady;
    logic [3:0] sofPID;
    logic [3:0] sendPacketCPPID;
    logic       sendPacketCPWEn;
    logic       sendPacketCPReady;

    int errors = 0;
    int checks = 0;

    int own = NONE;
    int last = HC;
    int cool = 0;
    bit mbusy = 1'b0;

    always #5 clk = ~clk;

    send_packet_arbiter #(.INTER_GRANT_GAP(GAP_N)) dut (
        .clk(clk),
        .rst(rst),
        .hcReq(hcReq),
        .hcPID(hcPID),
        .hcWEn(hcWEn),
        .hcGnt(hcGnt),
        .hcReady(hcReady),
        .sofReq(sofReq),
        .sofPID(sofPID),
        .sofWEn(sofWEn),
        .sofGnt(sofGnt),
        .sofReady(sofReady),
        .sendPacketCPPID(sendPacketCPPID),
        .sendPacketCPWEn(sendPacketCPWEn),
        .sendPacketCPReady(sendPacketCPReady)
    );

    task automatic chk(string tag, logic [3:0] obs, logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at %0t",
                   tag, obs, exp, $time);
        end
    endtask

    // Ownership advances on each edge from the inputs seen at that edge.
    task automatic model_edge();
        bit w, r;
        int win;
        if (rst) begin
            own = NONE; mbusy = 0; cool = 0; last = HC;
        end else if (own != NONE) begin
            w = (own == HC) ? hcWEn : sofWEn;
            r = (own == HC) ? hcReq : sofReq;
            if (!r && !mbusy && !w) begin
                own = NONE; mbusy = 0; cool = GAP_N;
            end else if (w) begin
                mbusy = 1;
            end else if (sendPacketCPReady) begin
                mbusy = 0;
            end
        end else if (cool > 0) begin
            cool--;
        end else if (hcReq || sofReq) begin
            if (hcReq && sofReq) begin
`ifdef SEND_PACKET_ARB_RR_EN
                win = (last == HC) ? SOF : HC;
`else
                win = SOF;
`endif
            end else begin
                win = hcReq ? HC : SOF;
            end
            own = win;
            last = win;
        end
    endtask

    task automatic compare(string tag);
        logic       e_wen;
        logic [3:0] e_pid;
        e_wen = 1'b0;
        e_pid = 4'h0;
        if (own == HC) begin
            e_wen = hcWEn; e_pid = hcPID;
        end else if (own == SOF) begin
            e_wen = sofWEn; e_pid = sofPID;
        end
        chk({tag, ".hcGnt"}, {3'b0, hcGnt}, {3'b0, own == HC});
        chk({tag, ".sofGnt"}, {3'b0, sofGnt}, {3'b0, own == SOF});
        chk({tag, ".cpWEn"}, {3'b0, sendPacketCPWEn}, {3'b0, e_wen});
        chk({tag, ".cpPID"}, sendPacketCPPID, e_pid);
        chk({tag, ".hcReady"}, {3'b0, hcReady},
            {3'b0, sendPacketCPReady && own == HC});
        chk({tag, ".sofReady"}, {3'b0, sofReady},
            {3'b0, sendPacketCPReady && own == SOF});
    endtask

    task automatic step(string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare(tag);
    endtask

    initial begin
        rst = 1; hcReq = 0; hcWEn = 0; hcPID = 0;
        sofReq = 0; sofWEn = 0; sofPID = 0; sendPacketCPReady = 1;
        repeat (3) step("reset");
        chk("reset_pid", sendPacketCPPID, 4'h0);
        rst = 0;
        repeat (6) step("idle");

        // single HC transaction
        hcReq = 1; step("hc_req");
        chk("hc_latency", {3'b0, hcGnt}, 4'h1);
        step("hc_hold");
        hcWEn = 1; hcPID = 4'h1; step("hc_wen");
        chk("hc_cp_wen", {3'b0, sendPacketCPWEn}, 4'h1);
        chk("hc_cp_pid", sendPacketCPPID, 4'h1);
        hcWEn = 0; sendPacketCPReady = 0;
        repeat (8) step("hc_busy");
        sendPacketCPReady = 1; step("hc_rdy");
        chk("hc_ready", {3'b0, hcReady}, 4'h1);
        hcReq = 0; step("hc_rel");
        chk("hc_release", {3'b0, hcGnt}, 4'h0);
        sofReq = 1;
        step("gap1");
        chk("gap1_nogrant", {3'b0, sofGnt}, 4'h0);
        step("gap2");
        chk("gap2_nogrant", {3'b0, sofGnt}, 4'h0);
        step("gap_end");
        chk("gap_grant", {3'b0, sofGnt}, 4'h1);
        sofReq = 0;
        repeat (4) step("sof_rel");

        // HC drops request while its packet is still draining
        hcReq = 1; repeat (2) step("early_req");
        hcWEn = 1; hcPID = 4'h3; step("early_wen");
        hcWEn = 0; hcReq = 0; sendPacketCPReady = 0; sofReq = 1;
        repeat (8) step("early_busy");
        chk("early_hold", {3'b0, hcGnt}, 4'h1);
        sendPacketCPReady = 1; step("early_rdy");
        step("early_rel");
        chk("early_drop", {3'b0, hcGnt}, 4'h0);
        repeat (3) step("early_gap");
        chk("early_sof", {3'b0, sofGnt}, 4'h1);

        // SOF strobe while HC owns the port
        sofReq = 0; step("ns_sofrel");
        hcReq = 1; repeat (5) step("ns_hcreq");
        hcPID = 4'h2; sofWEn = 1; sofPID = 4'h5; step("nonowner");
        chk("nonowner_wen", {3'b0, sendPacketCPWEn}, 4'h0);
        chk("nonowner_pid", sendPacketCPPID, 4'h2);
        sofWEn = 0; hcReq = 0;
        repeat (4) step("ns_rel");

        // simultaneous requests
        rst = 1; step("tie_rst");
        rst = 0; step("tie_idle");
        hcReq = 1; sofReq = 1; step("tie1");
        chk("tie_first_sof", {3'b0, sofGnt}, 4'h1);
        sofReq = 0; step("tie1_rel");
        repeat (3) step("tie1_gap");
        chk("tie_then_hc", {3'b0, hcGnt}, 4'h1);
        hcReq = 0; repeat (4) step("tie1_hcrel");
        for (int i = 0; i < 3; i++) begin
            hcReq = 1; sofReq = 1; step("tie_rep");
            hcReq = 0; sofReq = 0; step("tie_rep_rel");
            repeat (3) step("tie_rep_gap");
        end

        // reset while SOF owns and is busy
        sofReq = 1; repeat (4) step("mr_req");
        sofWEn = 1; sofPID = 4'h7; step("mr_wen");
        sofWEn = 0; sendPacketCPReady = 0; step("mr_busy");
        rst = 1; step("mid_rst");
        chk("mid_rst_gnt", {3'b0, sofGnt}, 4'h0);
        chk("mid_rst_pid", sendPacketCPPID, 4'h0);
        rst = 0; sendPacketCPReady = 1; step("post_rst");
        chk("post_rst_gnt", {3'b0, sofGnt}, 4'h1);
        sofReq = 0; repeat (4) step("post_rel");

        for (int c = 0; c < 3000; c++) begin
            if (!hcReq) hcReq = ($urandom_range(3) == 0);
            else if (own == HC) hcReq = ($urandom_range(7) != 0);
            else hcReq = ($urandom_range(15) != 0);
            if (!sofReq) sofReq = ($urandom_range(3) == 0);
            else if (own == SOF) sofReq = ($urandom_range(7) != 0);
            else sofReq = ($urandom_range(15) != 0);
            if (own == HC) hcWEn = hcReq && ($urandom_range(5) == 0);
            else hcWEn = ($urandom_range(7) == 0);
            if (own == SOF) sofWEn = sofReq && ($urandom_range(5) == 0);
            else sofWEn = ($urandom_range(7) == 0);
            hcPID = 4'($urandom);
            sofPID = 4'($urandom);
            sendPacketCPReady = ($urandom_range(9) < 7);
            rst = ($urandom_range(299) == 0);
            step("rnd");
            chk("rnd_excl", {3'b0, hcGnt & sofGnt}, 4'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/send_packet_arbiter.md
Name: send_packet_arbiter

Overview:
- Two-requester arbiter that shares the single host-side send-packet/check-preamble port between the host transaction processor (HC) and the SOF transmitter (SOF).
- Grants exclusive ownership and muxes the owner's PID/write-enable onto the shared port.
- Holds ownership until the owner releases and its last packet has drained.
- Enforces a programmable idle gap between consecutive grants.

Parameters:
INTER_GRANT_GAP, 2, idle cycles (0..15) inserted after a grant is released before the next grant may issue.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
hcReq  input  1  HC requests port ownership; held high for the whole transaction
hcPID  input  4  HC packet PID
hcWEn  input  1  HC one-cycle packet write strobe
hcGnt  output  1  HC owns port
hcReady  output  1  sendPacketCPReady gated by hcGnt
sofReq  input  1  SOF transmitter requests ownership
sofPID  input  4  SOF packet PID
sofWEn  input  1  SOF one-cycle packet write strobe
sofGnt  output  1  SOF owns port
sofReady  output  1  sendPacketCPReady gated by sofGnt
sendPacketCPPID  output  4  PID to shared send-packet port
sendPacketCPWEn  output  1  write strobe to shared send-packet port
sendPacketCPReady  input  1  shared port ready (high = idle)

Behaviour:
- Reset:
  - state IDLE; hcGnt=0, sofGnt=0; busy=0; gap counter=0; lastOwner=HC.
  - Muxed outputs are 0: sendPacketCPPID=4'h0, sendPacketCPWEn=0, hcReady=0, sofReady=0.
  - Reset mid-transaction drops both grants on the next edge; no strobe is issued afterwards.
- Grants are registered. Muxed outputs are combinational from registered grants:
  - hcGnt: PID=hcPID, WEn=hcWEn.
  - sofGnt: PID=sofPID, WEn=sofWEn.
  - Neither: PID=0, WEn=0.
  - A non-owner's WEn is ignored and dropped.
- States:
  - IDLE:
    - Request sampled high at edge N gives grant high from edge N+1 (1-cycle latency).
    - Only hcReq -> HC_ACT. Only sofReq -> SOF_ACT.
    - Both high -> policy decides (default: SOF wins).
    - Grant the winner; set lastOwner.
  - HC_ACT / SOF_ACT:
    - busy sets on the edge after a muxed WEn=1.
    - busy clears on any later edge where sendPacketCPReady=1 and WEn=0.
    - WEn while busy=1 is a protocol error: still forwarded, no extra handling.
    - Release when owner's req=0 and busy=0. Grant drops at that edge.
    - Next state is GAP if INTER_GRANT_GAP>0, else IDLE.
    - If the owner drops req while busy=1, keep the grant until busy clears, then release.
  - GAP:
    - Load counter with INTER_GRANT_GAP on entry; decrement each cycle.
    - Go to IDLE when the counter reaches 1; no grants during GAP.
    - Requests arriving during GAP wait and are arbitrated in IDLE.
- Requests:
  - A request dropped before it is granted is forgotten (no latching).
  - A requester re-asserting immediately after release competes normally after GAP.
- Ready gating: hcReady = sendPacketCPReady & hcGnt; sofReady likewise.
- Never both grants high; never a grant change while busy=1.

Optional Feature:
- Macro: SEND_PACKET_ARB_RR_EN.
- Defined: round-robin policy. On simultaneous requests in IDLE, the requester that is not lastOwner wins. Reset lastOwner=HC, so SOF wins the first tie.
- Undefined: fixed priority. SOF always wins ties (frame timing is critical); lastOwner is still tracked but unused.

Test Plan:
- Reset then idle:
  - Stimulus: rst=1 for 3 cycles, all req=0.
  - Response: grants 0, sendPacketCPWEn=0, PID=4'h0.
- Single HC transaction:
  - Stimulus: hcReq=1 at cycle 10; hcWEn=1 with hcPID=4'h1 at cycle 12; Ready low cycles 13-20.
  - Response: hcGnt=1 from cycle 11; CP WEn=1, PID=4'h1 at cycle 12; hcReady=1 at cycle 21.
  - Then hcReq=0 at 22: hcGnt=0 at 23; no grant before 25 (INTER_GRANT_GAP=2).
- Early release while busy:
  - Stimulus: HC drops hcReq the cycle after its WEn, while Ready=0 for 8 cycles; sofReq=1 meanwhile.
  - Response: hcGnt held until Ready returns to 1; sofGnt rises only after the gap.
- Simultaneous requests, fixed priority:
  - Stimulus: hcReq=sofReq=1 at the same edge.
  - Response: sofGnt=1 first; after SOF releases plus gap, hcGnt=1.
  - With SEND_PACKET_ARB_RR_EN: repeated ties alternate SOF, HC, SOF.
- Non-owner strobe:
  - Stimulus: during hcGnt, sofWEn=1 with sofPID=4'h5.
  - Response: sendPacketCPWEn stays 0; PID unchanged.
- Reset mid-operation:
  - Stimulus: rst=1 one cycle while sofGnt=1 and busy=1.
  - Response: all outputs 0 next cycle; state IDLE; fresh request granted with 1-cycle latency.
